// File: rtl/spi_host_win_initiator.sv
// spi_host_win_initiator: streams TX words into and RX words out of the SPI host data windows over regbus
module spi_host_win_initiator #(
   parameter type reg_req_t = struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   },
   parameter type reg_rsp_t = struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   },
   parameter logic [31:0] TxAddr = 32'h0,
   parameter logic [31:0] RxAddr = 32'h0,
   parameter int unsigned CntW   = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output reg_req_t        reg_req_o,
   input  reg_rsp_t        reg_rsp_i,
   input  logic [31:0]     tx_data_i,
   input  logic [3:0]      tx_be_i,
   input  logic            tx_valid_i,
   output logic            tx_ready_o,
   input  logic            rx_start_i,
   input  logic [CntW-1:0] rx_len_i,
   output logic            rx_busy_o,
   output logic [31:0]     rx_data_o,
   output logic            rx_valid_o,
   input  logic            rx_ready_i,
   output logic            err_o,
   input  logic            err_clr_i
);
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
   typedef enum logic {GNT_TX, GNT_RX} gnt_t;
   state_t          state;
   gnt_t            last_gnt;
   logic [CntW-1:0] remaining;
   logic            rx_elig;
   assign rx_elig    = (remaining != '0) & ~rx_valid_o;
   assign tx_ready_o = (state == IDLE) & ~rst_i & ~(rx_elig & (last_gnt == GNT_TX));
   assign rx_busy_o  = (remaining != '0) | (state == READ);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_gnt   <= GNT_RX;
         remaining  <= '0;
         reg_req_o  <= '0;
         rx_valid_o <= 1'b0;
         rx_data_o  <= '0;
         err_o      <= 1'b0;
      end else begin
         if (err_clr_i) err_o <= 1'b0;
         if (rx_valid_o & rx_ready_i) rx_valid_o <= 1'b0;
         if (rx_start_i & ~rx_busy_o) remaining <= rx_len_i;
         if (state == IDLE) begin
            if (tx_valid_i & tx_ready_o) begin
               reg_req_o.addr  <= TxAddr;
               reg_req_o.write <= 1'b1;
               reg_req_o.wdata <= tx_data_i;
               reg_req_o.wstrb <= tx_be_i;
               reg_req_o.valid <= 1'b1;
               last_gnt        <= GNT_TX;
               state           <= WRITE;
            end else if (rx_elig) begin
               reg_req_o.addr  <= RxAddr;
               reg_req_o.write <= 1'b0;
               reg_req_o.wdata <= '0;
               reg_req_o.wstrb <= '0;
               reg_req_o.valid <= 1'b1;
               last_gnt        <= GNT_RX;
               state           <= READ;
            end
         end else if (reg_rsp_i.ready) begin
            reg_req_o.valid <= 1'b0;
            state           <= IDLE;
            if (reg_rsp_i.error) err_o <= 1'b1;
            if (state == READ) begin
               if (remaining != '0) remaining <= remaining - CntW'(1);
               if (!reg_rsp_i.error) begin
                  rx_data_o  <= reg_rsp_i.rdata;
                  rx_valid_o <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_host_win_initiator.sv
// tb_spi_host_win_initiator: directed table, corner sequences and randomized traffic against a transaction-level model
module tb_spi_host_win_initiator;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } req_t;
   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } rsp_t;
   typedef struct {
      logic [31:0] data;
      logic [3:0]  be;
      int          wt;
      int          hold;
   } tv_t;
   localparam logic [31:0] TXA = 32'h1000_0010;
   localparam logic [31:0] RXA = 32'h1000_0020;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   req_t        req;
   rsp_t        rsp = '0;
   logic [31:0] tx_data = '0;
   logic [3:0]  tx_be = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        rx_start = 1'b0;
   logic [15:0] rx_len = '0;
   logic        rx_busy;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        err;
   logic        err_clr = 1'b0;
   int checks = 0;
   int errors = 0;
   int model_rem = 0;
   logic model_err = 1'b0;
   logic model_last_tx = 1'b0;
   logic [31:0] pend[$];
   logic [35:0] txq[$];
   logic [31:0] rq[$];
   bit glog[$];
   int cnt = 0;
   int hold = 0;
   int wait_cfg = 0;
   int cur_wait = 0;
   bit wait_rand = 0;
   bit err_next = 0;
   bit err_rand = 0;
   req_t cap;
   always #5 clk = ~clk;
   spi_host_win_initiator #(
      .reg_req_t(req_t), .reg_rsp_t(rsp_t), .TxAddr(TXA), .RxAddr(RXA), .CntW(16)
   ) dut (
      .clk_i(clk), .rst_i(rst), .reg_req_o(req), .reg_rsp_i(rsp),
      .tx_data_i(tx_data), .tx_be_i(tx_be), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
      .rx_start_i(rx_start), .rx_len_i(rx_len), .rx_busy_o(rx_busy),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .err_o(err), .err_clr_i(err_clr)
   );
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_idle(input int lim);
      int n = 0;
      while ((rx_busy || req.valid || rx_valid) && n < lim) begin
         step();
         n++;
      end
      chk("idle_timeout", n < lim, 1'b1);
   endtask
   function automatic int count_reads();
      int r = 0;
      foreach (glog[i]) if (!glog[i]) r++;
      return r;
   endfunction
   // model checks for this cycle first, then applies what the coming edge will do
   always @(negedge clk) begin
      if (rst) begin
         model_rem = 0;
         model_err = 1'b0;
         model_last_tx = 1'b0;
         pend.delete();
         txq.delete();
         cnt = 0;
         rsp = '0;
      end else begin
         chk("rx_busy", rx_busy, model_rem != 0);
         chk("err", err, model_err);
         chk("rx_valid", rx_valid, pend.size() != 0);
         if (pend.size() != 0) chk("rx_data", rx_data, pend[0]);
         chk("tx_ready", tx_ready, !req.valid && !(model_rem != 0 && pend.size() == 0 && model_last_tx));
         rsp = '0;
         if (rx_start && model_rem == 0) model_rem = int'(rx_len);
         if (pend.size() != 0 && rx_ready) void'(pend.pop_front());
         if (req.valid) begin
            if (cnt == 0) begin
               cap = req;
               hold = 0;
               cur_wait = wait_rand ? int'($urandom_range(0, 2)) : wait_cfg;
               model_last_tx = req.write;
               if (req.write) begin
                  if (txq.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL wr_unexpected: got write %0h with no accepted word", req.wdata);
                  end else begin
                     chk("wr_addr", req.addr, TXA);
                     chk("wr_data", {req.wdata, req.wstrb}, txq.pop_front());
                  end
               end else begin
                  chk("rd_addr", req.addr, RXA);
                  chk("rd_wdata", {req.wdata, req.wstrb}, 36'h0);
               end
            end else chk("req_stable", req, cap);
            hold++;
            if (cnt >= cur_wait) begin
               rsp.ready = 1'b1;
               rsp.rdata = rq.size() != 0 ? rq.pop_front() : $urandom;
               rsp.error = err_next | (err_rand && $urandom_range(0, 7) == 0);
               err_next = 0;
               cnt = 0;
               glog.push_back(req.write);
               if (!req.write) begin
                  model_rem--;
                  if (!rsp.error) pend.push_back(rsp.rdata);
               end
            end else cnt++;
         end else cnt = 0;
         if (rsp.ready && rsp.error) model_err = 1'b1;
         else if (err_clr) model_err = 1'b0;
         if (tx_valid && tx_ready) txq.push_back({tx_data, tx_be});
      end
   end
   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      tv_t tv[4];
      bit exp_g[6];
      int n;
      tv[0] = '{32'hDEADBEEF, 4'hF, 3, 4};
      tv[1] = '{32'h0123_4567, 4'h0, 0, 1};
      tv[2] = '{32'hA5A5_5A5A, 4'h5, 1, 2};
      tv[3] = '{32'hFFFF_0000, 4'hC, 2, 3};
      exp_g = '{1, 0, 1, 0, 1, 1};
      repeat (2) step();
      chk("rst_req", req, '0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, 32'h0);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", rx_busy, 1'b0);
      rst = 1'b0;
      step();
      foreach (tv[i]) begin
         wait_cfg = tv[i].wt;
         tx_data = tv[i].data;
         tx_be = tv[i].be;
         tx_valid = 1'b1;
         step();
         tx_valid = 1'b0;
         chk("tx_req_valid", req.valid, 1'b1);
         chk("tx_req_write", req.write, 1'b1);
         chk("tx_req_addr", req.addr, TXA);
         chk("tx_req_wdata", req.wdata, tv[i].data);
         chk("tx_req_wstrb", req.wstrb, tv[i].be);
         n = 0;
         while (req.valid && n < 10) begin
            chk("tx_ready_busy", tx_ready, 1'b0);
            step();
            n++;
         end
         chk("tx_hold", n, tv[i].hold);
         chk("tx_ready_after", tx_ready, 1'b1);
      end
      wait_cfg = 0;
      rx_ready = 1'b0;
      rq = '{32'h11, 32'h22, 32'h33};
      glog.delete();
      rx_len = 16'd3;
      rx_start = 1'b1;
      step();
      rx_start = 1'b0;
      n = 0;
      while (!rx_valid && n < 20) begin
         step();
         n++;
      end
      chk("rx_first", rx_data, 32'h11);
      repeat (5) begin
         chk("rx_bp_noreq", req.valid, 1'b0);
         chk("rx_bp_busy", rx_busy, 1'b1);
         step();
      end
      chk("rx_bp_reads", glog.size(), 1);
      rx_ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
         step();
         n = 0;
         while (!rx_valid && n < 20) begin
            step();
            n++;
         end
         chk("rx_word", rx_data, k == 1 ? 32'h22 : 32'h33);
      end
      chk("rx_busy_done", rx_busy, 1'b0);
      step();
      chk("rx_reads", count_reads(), 3);
      glog.delete();
      tx_valid = 1'b1;
      rx_len = 16'd2;
      rx_start = 1'b1;
      for (int c = 0; c < 14; c++) begin
         tx_data = $urandom;
         tx_be = 4'($urandom);
         step();
         rx_start = 1'b0;
      end
      tx_valid = 1'b0;
      wait_idle(50);
      chk("arb_count", glog.size() >= 6, 1'b1);
      if (glog.size() >= 6) foreach (exp_g[i]) chk("arb_order", glog[i], exp_g[i]);
      chk("arb_reads", count_reads(), 2);
      glog.delete();
      rq = '{32'h55};
      err_next = 1;
      rx_len = 16'd1;
      rx_start = 1'b1;
      step();
      rx_start = 1'b0;
      n = 0;
      while (!(req.valid && !req.write) && n < 20) begin
         step();
         n++;
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err_set", err, 1'b1);
      chk("err_rx_valid", rx_valid, 1'b0);
      chk("err_busy", rx_busy, 1'b0);
      step();
      chk("err_sticky", err, 1'b1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err_clear", err, 1'b0);
      rx_len = 16'd0;
      rx_start = 1'b1;
      step();
      rx_start = 1'b0;
      chk("len0_busy", rx_busy, 1'b0);
      chk("len0_noreq", req.valid, 1'b0);
      wait_cfg = 100;
      rx_len = 16'd3;
      rx_start = 1'b1;
      step();
      rx_start = 1'b0;
      n = 0;
      while (!(req.valid && !req.write) && n < 20) begin
         step();
         n++;
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", req.valid, 1'b0);
      chk("midrst_busy", rx_busy, 1'b0);
      chk("midrst_rx_valid", rx_valid, 1'b0);
      wait_cfg = 0;
      step();
      glog.delete();
      rx_len = 16'd2;
      rx_start = 1'b1;
      step();
      rx_len = 16'd5;
      step();
      rx_start = 1'b0;
      wait_idle(100);
      chk("ign_reads", count_reads(), 2);
      wait_rand = 1;
      err_rand = 1;
      for (int c = 0; c < 3000; c++) begin
         tx_valid = ($urandom_range(0, 2) == 0);
         tx_data = $urandom;
         tx_be = 4'($urandom);
         rx_ready = 1'($urandom_range(0, 1));
         rx_start = ($urandom_range(0, 11) == 0);
         rx_len = 16'($urandom_range(0, 4));
         err_clr = ($urandom_range(0, 31) == 0);
         rst = (c % 1000 == 999);
         step();
      end
      tx_valid = 1'b0;
      rx_start = 1'b0;
      err_clr = 1'b0;
      rst = 1'b0;
      rx_ready = 1'b1;
      err_rand = 0;
      wait_idle(200);
      step();
      chk("tx_drain", txq.size(), 0);
      chk("rx_drain", pend.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_host_win_initiator.md
# spi_host_win_initiator

Register-bus initiator that drives the SPI host's TX and RX data FIFO windows from the fabric side. It converts an incoming valid/ready word stream (data plus byte enables) into single-word regbus writes to the TX window. It also issues a programmed number of regbus reads to the RX window and returns the read data as a valid/ready output stream. It sits between a streaming producer/consumer (for example a DMA front end) and the SPI host register interface, with one outstanding regbus transaction at a time.

## Interface
Parameters:
- reg_req_t, logic, regbus request struct (addr, write, wdata, wstrb, valid); wdata is 32 bit.
- reg_rsp_t, logic, regbus response struct (rdata, error, ready).
- TxAddr, 32'h0, regbus address of the TX data window.
- RxAddr, 32'h0, regbus address of the RX data window.
- CntW, 16, width of the RX word counter.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - clk_i  in  1  clock.
  - rst_i  in  1  synchronous active-high reset.
- Regbus:
  - reg_req_o  out  reg_req_t  regbus request, fully registered.
  - reg_rsp_i  in  reg_rsp_t  regbus response.
- TX stream in:
  - tx_data_i  in  32  TX word.
  - tx_be_i  in  4  TX byte enables, driven onto wstrb.
  - tx_valid_i  in  1  TX word valid.
  - tx_ready_o  out  1  TX word accepted when high with tx_valid_i.
- RX read program:
  - rx_start_i  in  1  single-cycle pulse; loads rx_len_i into the remaining-reads counter.
  - rx_len_i  in  CntW  number of RX window reads to perform.
  - rx_busy_o  out  1  remaining-reads counter non-zero, or a read is in flight.
- RX stream out:
  - rx_data_o  out  32  RX word.
  - rx_valid_o  out  1  RX output register full.
  - rx_ready_i  in  1  consumer accepts rx_data_o.
- Error status:
  - err_o  out  1  sticky; set on any response with error=1.
  - err_clr_i  in  1  clears err_o.

## Operation
- FSM states: IDLE, WRITE, READ.
- **IDLE**
  - rx_elig = (remaining != 0) & ~rx_valid_o.
  - last_gnt register: reset value RX.
  - Arbitration is round-robin. When both TX and RX could go, the side not granted last wins.
  - tx_ready_o = IDLE & ~rst_i & ~(rx_elig & last_gnt==TX).
  - tx_valid_i & tx_ready_o: register addr=TxAddr, write=1, wdata=tx_data_i, wstrb=tx_be_i, valid=1; last_gnt<=TX; go to WRITE.
  - Else if rx_elig: register addr=RxAddr, write=0, wdata=0, wstrb=0, valid=1; last_gnt<=RX; go to READ.
- **WRITE / READ**
  - All reg_req_o fields are held stable until reg_rsp_i.ready=1.
  - On ready: valid<=0 and return to IDLE.
  - tx_ready_o=0 in these states.
- **Read completion** (READ & ready):
  - remaining decrements by 1.
  - If error=0: rx_data_o<=rdata and rx_valid_o<=1.
  - If error=1: the data is dropped and rx_valid_o is unchanged.
- **Write completion**: a write with wstrb=0 is still issued.
- **Response error**: err_o<=1. If err_clr_i is high in the same cycle, set wins.
- **RX output register** (one entry): cleared on rx_valid_o & rx_ready_i. A read is only issued while it is empty, so RX data is never overwritten.
- **rx_start_i**
  - Ignored while rx_busy_o=1.
  - rx_len_i=0 has no effect.
- **Counter**: remaining never wraps below 0.
- **rx_busy_o** = (remaining != 0) | (state==READ).

## Timing
- Reset values:
  - reg_req_o: all fields 0.
  - tx_ready_o: 0 while rst_i is high.
  - rx_valid_o=0, rx_data_o=0, err_o=0, rx_busy_o=0.
  - remaining=0, state=IDLE, last_gnt=RX.
- rst_i asserted mid-transaction: reg_req_o.valid drops at the next edge and the transaction is abandoned. A pending rx_valid_o word is discarded.
- Handshake latency:
  - TX accept at edge N gives reg_req_o.valid=1 from cycle N+1.
  - With ready=1 in cycle N+1, state is IDLE in cycle N+2. Peak rate is one transaction per 2 cycles.
- RX data is visible on rx_data_o in the cycle after the read response with ready=1.
- rx_ready_i is combinationally used only to clear the output register, never to drive reg_req_o.

## Test plan
- **TX single write**
  - Stimulus: after reset, tx_data_i=0xDEADBEEF, tx_be_i=0xF, valid; rsp ready after 3 wait cycles.
  - Required: reg_req_o addr=TxAddr, write=1, wstrb=0xF held 4 cycles. tx_ready_o low until the cycle after ready.
- **RX burst with backpressure**
  - Stimulus: rx_start_i with rx_len_i=3; rdata 0x11, 0x22, 0x33; rx_ready_i low for 5 cycles after the first word.
  - Required: three reads at RxAddr, in order. The second read is not issued until the first word is consumed. rx_busy_o drops after the third response.
- **Arbitration**
  - Stimulus: tx_valid_i held high continuously, rx_len_i=2, rx_ready_i=1.
  - Required: grant order TX, RX, TX, RX, then TX only.
- **Error handling**
  - Stimulus: read response with error=1 and rdata=0x55; err_clr_i pulsed in the same cycle.
  - Required: rx_valid_o stays 0, remaining decrements, err_o=1.
  - Follow-up: a later err_clr_i alone clears err_o.
- **Reset mid-operation**
  - Stimulus: rst_i high while in READ with ready=0.
  - Required: next cycle valid=0, remaining=0, rx_busy_o=0, rx_valid_o=0.
- **Ignored start**
  - Stimulus: rx_start_i with rx_len_i=5 while busy with 2 remaining.
  - Required: exactly 2 further reads occur.
